// File: rtl/grf_scoreboard.sv
// grf_scoreboard: parametrised general register file for the pipelined datapath.
// NUM_RD combinational read ports, one synchronous write port, same-cycle
// write-to-read bypass and a per-register pending (scoreboard) bit.
// Register 0 is hardwired to zero and is never pending.
// Optional feature: define GRF_SCOREBOARD_TRACE_EN to print a log line for
// every architectural register write (wr_pc is used only by that trace).
module grf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [31:0]              wr_pc,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_next;
  logic [ADDR_W:0]   cnt_next;
  logic              wr_hit;
  logic              iss_hit;

  // Writes and issues to register 0 are architecturally meaningless.
  assign wr_hit  = wr_en  && (wr_addr  != '0);
  assign iss_hit = iss_en && (iss_addr != '0);

  // Next pending vector: issue is applied after writeback so a new producer
  // supersedes a retiring one on the same register.
  always_comb begin
    pend_next = pend;
    if (wr_hit) begin
      pend_next[wr_addr] = 1'b0;
    end
    if (iss_hit) begin
      pend_next[iss_addr] = 1'b1;
    end
    pend_next[0] = 1'b0;
  end

  // Popcount of the next pending vector, registered into pend_cnt.
  always_comb begin
    cnt_next = '0;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_next = cnt_next + (ADDR_W+1)'(pend_next[r]);
    end
  end

  // Register array: async clear, writes to register 0 are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard state and its population count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_next;
      pend_cnt <= cnt_next;
    end
  end

  // Read ports are fully independent copies of the same lookup.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] data_q;
    logic              pend_q;

    assign a = rd_addr[i*ADDR_W +: ADDR_W];

    // Zero register, bypass from the write port, else array plus pending bit.
    // Reset gates the bypass so every port reads zero while reset is low.
    always_comb begin
      data_q = '0;
      pend_q = 1'b0;
      if (reset && (a != '0)) begin
        if (wr_en && (wr_addr == a)) begin
          data_q = wr_data;
        end else begin
          data_q = regs[a];
          pend_q = pend[a];
        end
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data_q;
    assign rd_pending[i]               = pend_q;
  end

`ifdef GRF_SCOREBOARD_TRACE_EN
  // Write trace for simulation logs; register 0 writes are not reported.
  always @(posedge clk) begin
    if (reset && wr_hit) begin
      $display("@%h: $%d <= %h", wr_pc, wr_addr, wr_data);
    end
  end
`else
  // The PC is only meaningful to the trace; fold it away otherwise.
  logic unused_wr_pc;
  assign unused_wr_pc = ^wr_pc;
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// tb_grf_scoreboard: self-checking bench for grf_scoreboard with a reference
// register/scoreboard model and an expected-value queue.
module tb_grf_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                     clk;
  logic                     reset;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [31:0]              wr_pc;
  logic [ADDR_W:0]          pend_cnt;

  int total;
  int bad;

  logic [31:0]       expQ [$];
  logic [DATA_W-1:0] mRegs [DEPTH];
  logic [DEPTH-1:0]  mPend;
  int                mCnt;

  grf_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .iss_en     (iss_en),
    .iss_addr   (iss_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_pc      (wr_pc),
    .pend_cnt   (pend_cnt)
  );

  // 10 ns clock; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Clears the reference model, mirroring an asynchronous reset.
  task automatic modelReset();
    for (int r = 0; r < DEPTH; r++) mRegs[r] = '0;
    mPend = '0;
    mCnt  = 0;
  endtask

  // Expected combinational read for one address under the current inputs.
  task automatic pushRead(input logic [ADDR_W-1:0] a);
    if (a == 0) begin
      expQ.push_back(32'h0);
      expQ.push_back(32'h0);
    end else if (wr_en && wr_addr == a) begin
      expQ.push_back(wr_data);
      expQ.push_back(32'h0);
    end else begin
      expQ.push_back(mRegs[a]);
      expQ.push_back({31'b0, mPend[a]});
    end
  endtask

  // Drives one cycle of stimulus (entered at a falling edge), checks both
  // read ports before the rising edge and pend_cnt just after it.
  task automatic applyStimulus(input logic ie, input logic [ADDR_W-1:0] ia,
                               input logic we, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd,
                               input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    logic [31:0] e;
    iss_en   = ie;
    iss_addr = ia;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rd_addr  = {a1, a0};
    pushRead(a0);
    pushRead(a1);
    #2;
    e = expQ.pop_front(); checkOutput("rd_data0",    rd_data[31:0],           e);
    e = expQ.pop_front(); checkOutput("rd_pending0", {31'b0, rd_pending[0]},  e);
    e = expQ.pop_front(); checkOutput("rd_data1",    rd_data[63:32],          e);
    e = expQ.pop_front(); checkOutput("rd_pending1", {31'b0, rd_pending[1]}, e);
    @(posedge clk);
    if (we && wa != 0) mRegs[wa] = wd;
    if (we && wa != 0) mPend[wa] = 1'b0;
    if (ie && ia != 0) mPend[ia] = 1'b1;
    mCnt = $countones(mPend);
    expQ.push_back(32'(mCnt));
    #1;
    e = expQ.pop_front(); checkOutput("pend_cnt", 32'(pend_cnt), e);
    @(negedge clk);
  endtask

  // Asserts reset between edges with a live write on the bus, checks that
  // outputs clear without a clock, holds it across an edge, then releases.
  task automatic doReset();
    #2;
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hBAD0BAD0;
    iss_en  = 1'b1;
    iss_addr = 5'd5;
    rd_addr = {5'd5, 5'd5};
    reset   = 1'b0;
    #1;
    checkOutput("rst_rd_data0",  rd_data[31:0],          32'h0);
    checkOutput("rst_rd_data1",  rd_data[63:32],         32'h0);
    checkOutput("rst_pending",   {30'b0, rd_pending},    32'h0);
    checkOutput("rst_pend_cnt",  32'(pend_cnt),          32'h0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    iss_en = 1'b0;
    wr_en  = 1'b0;
    reset  = 1'b1;
  endtask

  initial begin
    logic [31:0] cntBefore;
    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    iss_en   = 1'b0;
    iss_addr = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_pc    = '0;
    rd_addr  = '0;
    modelReset();
    #1;
    checkOutput("init_pend_cnt", 32'(pend_cnt), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Writes to register 0 never stick.
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0);
    checkOutput("reg0_data", rd_data[31:0], 32'h0);

    // Same-cycle bypass, then array read once the write has landed.
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd1);
    wr_en = 1'b0;
    #2;
    checkOutput("wr7_after", rd_data[31:0], 32'hDEADBEEF);
    @(negedge clk);

    // Issue reg3, wait, then write it back.
    applyStimulus(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    checkOutput("iss3_pending", {31'b0, rd_pending[0]}, 32'h1);
    checkOutput("iss3_cnt",     32'(pend_cnt),          32'h1);
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd3, 32'h42, 5'd3, 5'd3);
    checkOutput("wb3_cnt", 32'(pend_cnt), 32'h0);

    // Issue and writeback on the same register in the same cycle.
    applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    cntBefore = 32'(pend_cnt);
    applyStimulus(1'b1, 5'd9, 1'b1, 5'd9, 32'h11, 5'd9, 5'd9);
    checkOutput("iw9_cnt", 32'(pend_cnt), cntBefore);
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd3);
    checkOutput("iw9_data",    rd_data[31:0],          32'h11);
    checkOutput("iw9_pending", {31'b0, rd_pending[0]}, 32'h1);

    // Asynchronous reset mid-run after writing reg5.
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd5, 32'h1234, 5'd5, 5'd0);
    wr_en = 1'b0;
    #1;
    checkOutput("reg5_before_rst", rd_data[31:0], 32'h1234);
    doReset();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
    checkOutput("reg5_after_rst", rd_data[31:0], 32'h0);

    // Ramp every register to pending.
    for (int r = 1; r < DEPTH; r++) begin
      applyStimulus(1'b1, ADDR_W'(r), 1'b0, 5'd0, 32'h0, ADDR_W'(r), 5'd0);
    end
    checkOutput("ramp_cnt", 32'(pend_cnt), 32'(DEPTH-1));
    wr_pc = 32'h3000;
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd4, 32'hA, 5'd4, 5'd31);
    checkOutput("ramp_wb4_cnt", 32'(pend_cnt), 32'(DEPTH-2));

    // Random traffic concentrated on a few registers to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      wr_pc = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
                    $urandom,
                    ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Parametrised successor to the single-port general register file, for the pipelined datapath.
- Provides NUM_RD combinational read ports, one synchronous write port, write-to-read bypass and a per-register pending (scoreboard) bit.
- Issue stage marks a destination register pending; writeback clears it. Decode uses rd_pending to stall.
- Register 0 is hardwired to zero and is never pending.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of read ports (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
rd_addr  input  NUM_RD*ADDR_W  read addresses; port i is bits [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  read data; port i is bits [i*DATA_W +: DATA_W]
rd_pending  output  NUM_RD  1 = port i's register awaits an outstanding writeback
iss_en  input  1  issue: mark iss_addr pending
iss_addr  input  ADDR_W  destination of the issued instruction
wr_en  input  1  writeback enable
wr_addr  input  ADDR_W  writeback register
wr_data  input  DATA_W  writeback value
wr_pc  input  32  PC of the writing instruction (trace only)
pend_cnt  output  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (reset==0) takes effect asynchronously, independent of clk.
  - All registers go to 0, all pending bits to 0, pend_cnt to 0.
  - rd_data follows combinationally, so every rd_data port reads 0 and every rd_pending reads 0 while reset is low.
  - Reset asserted mid-operation discards any in-flight write and issue.
- Write: on the rising edge with reset high, wr_en==1 and wr_addr!=0, reg[wr_addr] <= wr_data.
  - wr_addr==0 is ignored; reg 0 always reads 0.
- Read (combinational, per port i, a = rd_addr slice):
  - a==0 -> rd_data 0, rd_pending 0.
  - Else if wr_en && wr_addr==a -> rd_data = wr_data (same-cycle bypass), rd_pending 0.
  - Else rd_data = reg[a], rd_pending = pend[a].
- Pending update on the rising edge, per register r != 0:
  - Issue hit (iss_en && iss_addr==r) -> pend[r] <= 1. This takes priority over a simultaneous writeback to r, because the new producer supersedes the old one.
  - Else writeback hit (wr_en && wr_addr==r) -> pend[r] <= 0.
  - Else pend[r] holds.
  - iss_addr==0 has no effect.
  - Writeback to a non-pending register is legal: data is written and pend stays 0.
  - Issue to an already-pending register keeps it at 1. There is no counting; one writeback clears it.
- Issue is not visible on rd_pending until the following cycle.
- pend_cnt is registered and equals the popcount of pend after each edge. Range 0..DEPTH-1, so no overflow.
- All read ports are independent; identical addresses on several ports return identical results.
- Latency: write visible via bypass in the same cycle, from the array in the next cycle. Pending set/clear is visible in the next cycle.

Optional Feature:
- Macro: GRF_SCOREBOARD_TRACE_EN.
- Defined: on each rising edge with reset high, wr_en==1 and wr_addr!=0, execute $display("@%h: $%d <= %h", wr_pc, wr_addr, wr_data). Writes to register 0 are not printed.
- Undefined: no $display. wr_pc is unused, and the functional behaviour is identical.

Test Plan:
1. Hold reset low mid-run after writing reg5=0x1234 -> rd_data for reg5 reads 0 immediately, without a clk edge; pend_cnt=0.
2. Write wr_addr=0, wr_data=0xFFFFFFFF; read reg0 on all ports -> 0 every cycle, rd_pending 0.
3. wr_en=1, wr_addr=7, wr_data=0xDEADBEEF; in the same cycle rd_addr port0=7 -> rd_data0=0xDEADBEEF before the edge; after the edge, with wr_en=0, still 0xDEADBEEF.
4. Issue reg3 at cycle 0 -> rd_pending for 3 is 0 in cycle 0, 1 in cycle 1, pend_cnt=1. Writeback reg3=0x42 at cycle 4 -> rd_pending 0 and data 0x42 in cycle 4 via bypass; pend_cnt=0 in cycle 5.
5. Same cycle iss_en with iss_addr=9 and wr_en with wr_addr=9, wr_data=0x11 (reg9 pending) -> reg9=0x11 next cycle, pend[9] stays 1, pend_cnt unchanged.
6. Issue regs 1..31 in consecutive cycles -> pend_cnt ramps to 31. With GRF_SCOREBOARD_TRACE_EN, write reg4=0xA at wr_pc=0x3000 -> log line "@00003000: $ 4 <= 0000000a".
